// File: rtl/std_fifo_arbiter_if.sv
// Handshake bundle between upstream requesters, the arbiter and a std_fifo write port.
// slave = arbiter side, master = requester/FIFO environment side.
interface std_fifo_arbiter_if #(
    parameter int WIDTH    = 8,
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_push;
    logic [WIDTH-1:0]         fifo_d;
    logic                     fifo_full;
    logic                     fifo_almost_full;
    logic [ID_WIDTH-1:0]      grant_id;
    logic                     overflow_err;

    modport slave (
        input  req_valid, req_data, req_last,
        input  fifo_full, fifo_almost_full,
        output req_ready, fifo_push, fifo_d,
        output grant_id, overflow_err
    );

    modport master (
        output req_valid, req_data, req_last,
        output fifo_full, fifo_almost_full,
        input  req_ready, fifo_push, fifo_d,
        input  grant_id, overflow_err
    );
endinterface

// File: rtl/std_fifo_arbiter.sv
// Round-robin NUM_REQ:1 arbiter driving a std_fifo write port with a 1-cycle output register.
// Define STD_FIFO_ARB_LOCK_EN to compile in burst lock (grant held until req_last).
module std_fifo_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input logic               clk,
    input logic               rst,
    std_fifo_arbiter_if.slave bus
);
    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] cand;
    logic [ID_WIDTH-1:0] idx;
    logic [ID_WIDTH-1:0] nxt;
    logic                cand_vld;
    logic                stall;
    logic                accept;
    logic [NUM_REQ-1:0]  ready;
    logic [WIDTH-1:0]    beat;

    logic                push_q;
    logic [WIDTH-1:0]    data_q;
    logic [ID_WIDTH-1:0] gid_q;
    logic                ovf_q;

`ifdef STD_FIFO_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCK} state_e;
    state_e              state_q;
    logic [ID_WIDTH-1:0] owner_q;
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
`endif

    assign stall = bus.fifo_full | bus.fifo_almost_full;

    // Downward scan so the requester closest above ptr wins.
    always_comb begin
        cand     = ptr_q;
        cand_vld = 1'b0;
        idx      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
            if (bus.req_valid[idx]) begin
                cand     = idx;
                cand_vld = 1'b1;
            end
        end
`ifdef STD_FIFO_ARB_LOCK_EN
        if (state_q == LOCK) begin
            cand     = owner_q;
            cand_vld = 1'b1;
        end
`endif
    end

    always_comb begin
        ready = '0;
        if (cand_vld && !stall && !rst) begin
            ready[cand] = 1'b1;
        end
    end

    assign accept = |(ready & bus.req_valid);
    assign beat   = bus.req_data[int'(cand)*WIDTH +: WIDTH];
    assign nxt    = ID_WIDTH'((int'(cand) + 1) % NUM_REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            push_q  <= 1'b0;
            data_q  <= '0;
            gid_q   <= '0;
            ovf_q   <= 1'b0;
            ptr_q   <= '0;
`ifdef STD_FIFO_ARB_LOCK_EN
            state_q <= IDLE;
            owner_q <= '0;
`endif
        end else begin
            push_q <= accept;
            ovf_q  <= ovf_q | (push_q & bus.fifo_full);
            if (accept) begin
                data_q <= beat;
                gid_q  <= cand;
            end
`ifdef STD_FIFO_ARB_LOCK_EN
            if (accept) begin
                if (bus.req_last[cand]) begin
                    state_q <= IDLE;
                    ptr_q   <= nxt;
                end else begin
                    state_q <= LOCK;
                    owner_q <= cand;
                end
            end
`else
            if (accept) begin
                ptr_q <= nxt;
            end
`endif
        end
    end

    // Reset masks the output register so a beat latched just before rst is dropped.
    assign bus.req_ready    = ready;
    assign bus.fifo_push    = push_q & ~rst;
    assign bus.fifo_d       = rst ? '0 : data_q;
    assign bus.grant_id     = rst ? '0 : gid_q;
    assign bus.overflow_err = ovf_q & ~rst;
endmodule

// File: tb/tb_std_fifo_arbiter.sv
// Self-checking bench for std_fifo_arbiter: per-cycle compare against a behavioural model
// plus directed scenarios with literal expectations.
module tb_std_fifo_arbiter;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int IW = 2;
`ifdef STD_FIFO_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    bit   chk_on = 1'b0;
    int   cnt = 0;

    std_fifo_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .ID_WIDTH(IW)) bus ();

    std_fifo_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    int         m_ptr = 0;
    int         m_owner = 0;
    bit         m_lock = 1'b0;
    bit         m_push = 1'b0;
    bit         m_ovf = 1'b0;
    logic [W-1:0] m_d = '0;
    int         m_gid = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_ready();
        int j;
        if (rst || bus.fifo_full || bus.fifo_almost_full) return '0;
        if (m_lock) return N'(1) << m_owner;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (bus.req_valid[j]) return N'(1) << j;
        end
        return '0;
    endfunction

    always @(posedge clk) begin : model
        logic [N-1:0] acc;
        acc = model_ready() & bus.req_valid;
        if (rst) begin
            m_ptr = 0; m_owner = 0; m_lock = 0;
            m_push = 0; m_ovf = 0; m_d = '0; m_gid = 0;
        end else begin
            m_ovf  = m_ovf | (m_push & bus.fifo_full);
            m_push = (acc != '0);
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    m_d   = bus.req_data[i*W +: W];
                    m_gid = i;
                    if (LOCK_EN && !bus.req_last[i]) begin
                        m_lock  = 1'b1;
                        m_owner = i;
                    end else begin
                        m_lock = 1'b0;
                        m_ptr  = (i + 1) % N;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", 32'(bus.req_ready), 32'(model_ready()));
            chk("push", 32'(bus.fifo_push), rst ? 0 : 32'(m_push));
            chk("data", 32'(bus.fifo_d), rst ? 0 : 32'(m_d));
            chk("gid", 32'(bus.grant_id), rst ? 0 : 32'(m_gid));
            chk("ovf", 32'(bus.overflow_err), rst ? 0 : 32'(m_ovf));
        end
    end

    // Downstream FIFO occupancy, no pops
    always @(negedge clk) begin
        if (rst) cnt = 0;
        else if (bus.fifo_push) cnt++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [W-1:0] seq_d [4];
        seq_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.req_valid        = '0;
        bus.req_data         = '0;
        bus.req_last         = '0;
        bus.fifo_full        = 1'b0;
        bus.fifo_almost_full = 1'b0;
        rst = 1'b1;
        step();
        step();
        chk_on = 1'b1;
        bus.req_valid = '1;
        #1;
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_push", 32'(bus.fifo_push), 0);
        chk("rst_gid", 32'(bus.grant_id), 0);
        chk("rst_ovf", 32'(bus.overflow_err), 0);

        // Round-robin order 0,1,2,3,0
        rst = 1'b0;
        bus.req_data = 32'h44332211;
        for (int k = 0; k < 5; k++) begin
            step();
            #1;
            chk("seq_push", 32'(bus.fifo_push), 1);
            chk("seq_gid", 32'(bus.grant_id), 32'(k % 4));
            chk("seq_d", 32'(bus.fifo_d), 32'(seq_d[k%4]));
        end

        // Move ptr to 3, then wrap to requester 0
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = 4'b0001;
        bus.req_data  = 32'h000000A5;
        #1;
        chk("wrap_ready", 32'(bus.req_ready), 32'h1);
        step();
        #1;
        chk("wrap_push", 32'(bus.fifo_push), 1);
        chk("wrap_d", 32'(bus.fifo_d), 32'hA5);
        chk("wrap_gid", 32'(bus.grant_id), 0);

        // almost_full stall
        bus.fifo_almost_full = 1'b1;
        bus.req_valid = '1;
        repeat (5) begin
            #1;
            chk("af_ready", 32'(bus.req_ready), 0);
            step();
            #1;
            chk("af_push", 32'(bus.fifo_push), 0);
        end
        bus.fifo_almost_full = 1'b0;
        #1;
        chk("af_release", 32'(bus.req_ready), 32'h2);
        step();
        #1;
        chk("af_rel_push", 32'(bus.fifo_push), 1);
        chk("af_rel_gid", 32'(bus.grant_id), 1);

        // Reset right after an acceptance drops the beat
        step();
        rst = 1'b1;
        #1;
        chk("rdrop_push", 32'(bus.fifo_push), 0);
        chk("rdrop_d", 32'(bus.fifo_d), 0);
        chk("rdrop_gid", 32'(bus.grant_id), 0);
        chk("rdrop_ready", 32'(bus.req_ready), 0);
        step();
        rst = 1'b0;
        #1;
        chk("rdrop_ptr0", 32'(bus.req_ready), 32'h1);

        // 64-deep FIFO, ALMOST_FULL_COUNT=1, no pops
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (100) begin
            bus.fifo_full        = (cnt >= 64);
            bus.fifo_almost_full = (cnt >= 63);
            step();
        end
        chk("fifo_cnt", 32'(cnt), 64);
        chk("fifo_ovf", 32'(bus.overflow_err), 0);
        bus.fifo_full = 1'b0;
        bus.fifo_almost_full = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;

`ifdef STD_FIFO_ARB_LOCK_EN
        bus.req_valid = 4'b0110;
        bus.req_last  = 4'b0000;
        bus.req_data  = 32'h00C2B100;
        #1;
        chk("lk_ready0", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 4'b0100;
        #1;
        chk("lk_gid1", 32'(bus.grant_id), 1);
        chk("lk_hold", 32'(bus.req_ready), 32'h2);
        step();
        bus.req_valid = 4'b0110;
        bus.req_data  = 32'h00C2B200;
        step();
        #1;
        chk("lk_gid2", 32'(bus.grant_id), 1);
        bus.req_last = 4'b0010;
        bus.req_data = 32'h00C2B300;
        step();
        #1;
        chk("lk_gid3", 32'(bus.grant_id), 1);
        bus.req_valid = 4'b0100;
        bus.req_last  = 4'b0100;
        step();
        #1;
        chk("lk_gid4", 32'(bus.grant_id), 2);
        chk("lk_d4", 32'(bus.fifo_d), 32'hC2);
`endif

        // Randomised traffic
        repeat (3000) begin
            bus.req_valid        = N'($urandom);
            bus.req_data         = $urandom;
            bus.req_last         = N'($urandom);
            bus.fifo_full        = ($urandom_range(0, 7) == 0);
            bus.fifo_almost_full = ($urandom_range(0, 5) == 0);
            rst                  = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        step();
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
